// File: rtl/uart_tx_frame.sv
// ============================================================================
// Module      : uart_tx_frame
// Description : UART transmitter. Serialises one word per handshake, LSB
//               first, as start / data / optional parity / stop, with each
//               bit held for `prescale` clk cycles. Define UART_TX_STOP2_EN
//               to add the stop2 input (two stop bits when set).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_frame #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
`ifdef UART_TX_STOP2_EN
  input  logic                      stop2,
`endif
  output logic                      tx_out,
  output logic                      busy
);

  localparam int c_bit_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [c_bit_w-1:0]        c_last_bit = c_bit_w'(DATA_WIDTH - 1);
  localparam logic [c_bit_w-1:0]        c_bit_one  = c_bit_w'(1);
  localparam logic [PRESCALE_WIDTH-1:0] c_cnt_one  = PRESCALE_WIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t                    r_state;
  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic [c_bit_w-1:0]        r_bit_idx;
  logic [DATA_WIDTH-1:0]     r_data;
  logic                      r_par_en;
  logic                      r_par_bit;
`ifdef UART_TX_STOP2_EN
  logic                      r_stop2;
  logic                      r_stop_second;
`endif

  logic w_bit_end;

  // The edge counter runs 1..P, so a bit closes on the edge where it hits P.
  assign w_bit_end = (r_cnt == r_prescale);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      tx_out        <= 1'b1;
      busy          <= 1'b0;
      r_cnt         <= '0;
      r_prescale    <= '0;
      r_bit_idx     <= '0;
      r_data        <= '0;
      r_par_en      <= 1'b0;
      r_par_bit     <= 1'b0;
`ifdef UART_TX_STOP2_EN
      r_stop2       <= 1'b0;
      r_stop_second <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (data_valid && (prescale != '0)) begin
            r_data     <= p_data;
            r_par_en   <= par_en;
            r_par_bit  <= (^p_data) ^ par_typ;
            r_prescale <= prescale;
`ifdef UART_TX_STOP2_EN
            r_stop2       <= stop2;
            r_stop_second <= 1'b0;
`endif
            r_cnt      <= c_cnt_one;
            r_bit_idx  <= '0;
            tx_out     <= 1'b0;
            busy       <= 1'b1;
            r_state    <= ST_START;
          end
        end

        ST_START: begin
          if (w_bit_end) begin
            r_cnt   <= c_cnt_one;
            tx_out  <= r_data[0];
            r_state <= ST_DATA;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        ST_DATA: begin
          if (w_bit_end) begin
            r_cnt <= c_cnt_one;
            if (r_bit_idx == c_last_bit) begin
              if (r_par_en) begin
                tx_out  <= r_par_bit;
                r_state <= ST_PARITY;
              end else begin
                tx_out  <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              // Shift so the next bit to send is always at r_data[0].
              r_bit_idx <= r_bit_idx + c_bit_one;
              r_data    <= r_data >> 1;
              tx_out    <= r_data[1];
            end
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        ST_PARITY: begin
          if (w_bit_end) begin
            r_cnt   <= c_cnt_one;
            tx_out  <= 1'b1;
            r_state <= ST_STOP;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        ST_STOP: begin
          if (w_bit_end) begin
`ifdef UART_TX_STOP2_EN
            if (r_stop2 && !r_stop_second) begin
              r_stop_second <= 1'b1;
              r_cnt         <= c_cnt_one;
            end else begin
              r_cnt   <= '0;
              busy    <= 1'b0;
              r_state <= ST_IDLE;
            end
`else
            r_cnt   <= '0;
            busy    <= 1'b0;
            r_state <= ST_IDLE;
`endif
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end

        default: begin
          tx_out  <= 1'b1;
          busy    <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
// ============================================================================
// Module      : tb_uart_tx_frame
// Description : Directed self-checking bench for uart_tx_frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic       data_valid = 1'b0;
  logic       par_en = 1'b0;
  logic       par_typ = 1'b0;
  logic [5:0] prescale = 6'd0;
  logic       tx_out;
  logic       busy;
`ifdef UART_TX_STOP2_EN
  logic       stop2 = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(
    .DATA_WIDTH    (8),
    .PRESCALE_WIDTH(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .prescale  (prescale),
`ifdef UART_TX_STOP2_EN
    .stop2     (stop2),
`endif
    .tx_out    (tx_out),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Set inputs on a falling edge, return just after the next rising edge.
  task automatic drive(input logic [7:0] d, input logic pe, input logic pt,
                       input logic [5:0] ps, input logic dv);
    @(negedge clk);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    prescale   = ps;
    data_valid = dv;
    @(posedge clk);
    #1;
  endtask

  // Called just after an accept edge; samples each cycle on the falling edge
  // until busy drops. Frame bits are packed LSB = start bit.
  task automatic capture(input string tag, input int ps, input logic [15:0] exp_bits,
                         input int exp_len, output int tail_ones);
    int         len;
    logic [15:0] obs;
    logic       unstable;
    len       = 0;
    obs       = '0;
    unstable  = 1'b0;
    tail_ones = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!busy) break;
      if ((c / ps) < 16) begin
        if ((c % ps) == 0) obs[c / ps] = tx_out;
        else if (tx_out !== obs[c / ps]) unstable = 1'b1;
      end
      tail_ones = (tx_out === 1'b1) ? tail_ones + 1 : 0;
      len++;
    end
    if (tx_out === 1'b1) tail_ones++;
    check({tag, "_len"}, len, exp_len);
    check({tag, "_bits"}, {16'd0, obs}, {16'd0, exp_bits});
    check({tag, "_stable"}, {31'd0, unstable}, 32'd0);
    check({tag, "_idle_tx"}, {31'd0, tx_out}, 32'd1);
  endtask

  initial begin
    #50_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int tail;
    int tail_b2b;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {31'd0, tx_out}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5, no parity, prescale 8: 0,1,0,1,0,0,1,0,1,1
    drive(8'hA5, 1'b0, 1'b0, 6'd8, 1'b1);
    data_valid = 1'b0;
    capture("a5_np", 8, 16'h034A, 80, tail);

    // 0xA5, even parity -> parity 0
    drive(8'hA5, 1'b1, 1'b0, 6'd8, 1'b1);
    data_valid = 1'b0;
    capture("a5_even", 8, 16'h054A, 88, tail);

    // 0xA5, odd parity -> parity 1
    drive(8'hA5, 1'b1, 1'b1, 6'd8, 1'b1);
    data_valid = 1'b0;
    capture("a5_odd", 8, 16'h074A, 88, tail);

    // Back-to-back with data_valid held high
    drive(8'h3C, 1'b0, 1'b0, 6'd4, 1'b1);
    p_data = 8'hC3;
    capture("b2b_1", 4, 16'h0278, 40, tail_b2b);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    capture("b2b_2", 4, 16'h0386, 40, tail);
    check("b2b_gap", tail_b2b, 5);

    // Request during DATA is ignored and not queued
    drive(8'h55, 1'b0, 1'b0, 6'd8, 1'b1);
    data_valid = 1'b0;
    fork
      capture("ign_55", 8, 16'h02AA, 80, tail);
      begin
        repeat (20) @(posedge clk);
        #1;
        p_data     = 8'hFF;
        data_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        data_valid = 1'b0;
      end
    join
    @(negedge clk);
    check("ign_no_queue", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-frame (all-zero data keeps the line low)
    drive(8'h00, 1'b0, 1'b0, 6'd8, 1'b1);
    data_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd1);
    check("rst_mid_tx", {31'd0, tx_out}, 32'd0);
    #1;
    rst = 1'b0;
    #1;
    check("rst_async_tx", {31'd0, tx_out}, 32'd1);
    check("rst_async_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    drive(8'h81, 1'b0, 1'b0, 6'd8, 1'b1);
    data_valid = 1'b0;
    capture("post_rst_81", 8, 16'h0302, 80, tail);

    // prescale=0 never accepts
    drive(8'hFF, 1'b0, 1'b0, 6'd0, 1'b1);
    repeat (5) @(negedge clk);
    check("ps0_busy", {31'd0, busy}, 32'd0);
    check("ps0_tx", {31'd0, tx_out}, 32'd1);

    // prescale=1 with 0xFF: 10-cycle frame
    drive(8'hFF, 1'b0, 1'b0, 6'd1, 1'b1);
    data_valid = 1'b0;
    capture("ps1_ff", 1, 16'h03FE, 10, tail);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
